// File: rtl/axicb_mst_switch_wr_if.sv
// axicb_mst_switch_wr_if: bundled upstream-port and slave-side AW/W/B signals of the write switch
interface axicb_mst_switch_wr_if #(
    parameter int MST_NB = 4,
    parameter int AWCH_W = 8,
    parameter int WCH_W  = 8,
    parameter int BCH_W  = 8
);
    logic [MST_NB-1:0]        i_awvalid;
    logic [MST_NB-1:0]        i_awready;
    logic [MST_NB*AWCH_W-1:0] i_awch;
    logic [MST_NB-1:0]        i_wvalid;
    logic [MST_NB-1:0]        i_wready;
    logic [MST_NB-1:0]        i_wlast;
    logic [MST_NB*WCH_W-1:0]  i_wch;
    logic [MST_NB-1:0]        i_bvalid;
    logic [MST_NB-1:0]        i_bready;
    logic [BCH_W-1:0]         i_bch;
    logic                     o_awvalid;
    logic                     o_awready;
    logic [AWCH_W-1:0]        o_awch;
    logic                     o_wvalid;
    logic                     o_wready;
    logic                     o_wlast;
    logic [WCH_W-1:0]         o_wch;
    logic                     o_bvalid;
    logic                     o_bready;
    logic [BCH_W-1:0]         o_bch;
    modport master (
        input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
        input  o_awready, o_wready, o_bvalid, o_bch,
        output i_awready, i_wready, i_bvalid, i_bch,
        output o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready
    );
    modport slave (
        output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
        output o_awready, o_wready, o_bvalid, o_bch,
        input  i_awready, i_wready, i_bvalid, i_bch,
        input  o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready
    );
endinterface

// File: rtl/axicb_mst_switch_wr.sv
// axicb_mst_switch_wr: round-robin AW arbiter with in-order W and B routing through grant-order FIFOs
module axicb_mst_switch_wr #(
    parameter int MST_NB      = 4,
    parameter int AWCH_W      = 8,
    parameter int WCH_W       = 8,
    parameter int BCH_W       = 8,
    parameter int OSTDREQ_NUM = 4
) (
    input logic aclk,
    input logic aresetn,
    axicb_mst_switch_wr_if.master bus
);
    localparam int IW = $clog2(MST_NB);
    localparam int QW = $clog2(OSTDREQ_NUM);
    logic          live, lock, en, full, aw_hs, w_pop, b_pop, w_any, b_any;
    logic [IW-1:0] ptr, lgnt, arb, g, j, h, b;
    logic [IW-1:0] wq [OSTDREQ_NUM];
    logic [IW-1:0] bq [OSTDREQ_NUM];
    logic [QW-1:0] wwp, wrp, bwp, brp;
    logic [QW:0]   wcnt, bcnt;
    assign en    = aresetn & live;
    assign full  = (wcnt == (QW+1)'(OSTDREQ_NUM)) | (bcnt == (QW+1)'(OSTDREQ_NUM));
    // Round-robin search from ptr upward with wrap; scanning downward lets the nearest requester win
    always_comb begin
        arb = ptr;
        j   = ptr;
        for (int i = MST_NB - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % MST_NB);
            if (bus.i_awvalid[j]) arb = j;
        end
    end
    assign g             = lock ? lgnt : arb;
    assign bus.o_awvalid = en & ~full & bus.i_awvalid[g];
    assign bus.o_awch    = bus.i_awch[g*AWCH_W +: AWCH_W];
    assign bus.i_awready = bus.o_awvalid ? MST_NB'(bus.o_awready) << g : '0;
    assign aw_hs         = bus.o_awvalid & bus.o_awready;
    assign h             = wq[wrp];
    assign w_any         = en & (wcnt != '0);
    assign bus.o_wvalid  = w_any & bus.i_wvalid[h];
    assign bus.o_wlast   = bus.i_wlast[h];
    assign bus.o_wch     = bus.i_wch[h*WCH_W +: WCH_W];
    assign bus.i_wready  = w_any ? MST_NB'(bus.o_wready) << h : '0;
    assign w_pop         = bus.o_wvalid & bus.o_wready & bus.o_wlast;
    assign b             = bq[brp];
    assign b_any         = en & (bcnt != '0);
    assign bus.i_bvalid  = b_any ? MST_NB'(bus.o_bvalid) << b : '0;
    assign bus.o_bready  = b_any & bus.i_bready[b];
    assign bus.i_bch     = bus.o_bch;
    assign b_pop         = bus.o_bvalid & bus.o_bready;
    // Arbiter state: hold the grant while the slave stalls, advance the pointer past the winner on handshake
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            live <= 1'b0;
            lock <= 1'b0;
            ptr  <= '0;
            lgnt <= '0;
        end else begin
            live <= 1'b1;
            if (aw_hs) begin
                lock <= 1'b0;
                ptr  <= (g == IW'(MST_NB - 1)) ? '0 : g + 1'b1;
            end else if (bus.o_awvalid) begin
                lock <= 1'b1;
                lgnt <= g;
            end
        end
    end
    // Order FIFO pointers and occupancy; a push and pop together leave the count unchanged
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wwp  <= '0;
            wrp  <= '0;
            bwp  <= '0;
            brp  <= '0;
            wcnt <= '0;
            bcnt <= '0;
        end else begin
            wwp  <= wwp + QW'(aw_hs);
            bwp  <= bwp + QW'(aw_hs);
            wrp  <= wrp + QW'(w_pop);
            brp  <= brp + QW'(b_pop);
            wcnt <= wcnt + (QW+1)'(aw_hs) - (QW+1)'(w_pop);
            bcnt <= bcnt + (QW+1)'(aw_hs) - (QW+1)'(b_pop);
        end
    end
    // Order FIFO storage: record the granted port for both the W and B paths
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            wq[wwp] <= g;
            bq[bwp] <= g;
        end
    end
endmodule

// File: tb/tb_axicb_mst_switch_wr.sv
// tb_axicb_mst_switch_wr: vector table, directed corner sequences and a queue-based reference model under random traffic
module tb_axicb_mst_switch_wr;
    localparam int N = 4, AW = 8, WW = 8, BW = 8, D = 4;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;
    axicb_mst_switch_wr_if #(.MST_NB(N), .AWCH_W(AW), .WCH_W(WW), .BCH_W(BW)) bus ();
    axicb_mst_switch_wr #(.MST_NB(N), .AWCH_W(AW), .WCH_W(WW), .BCH_W(BW), .OSTDREQ_NUM(D)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );
    int n_chk = 0, n_pass = 0;
    bit use_model = 1'b0;
    // Reference model: grant order kept in plain queues
    int wq[$], bq[$];
    int ptr = 0, locked = -1, g = -1, h = -1, b = -1;
    bit live = 1'b0;
    logic e_awv, e_wv, e_br;
    logic [N-1:0] e_awr, e_wr, e_bv;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_eval();
        bit en, full;
        en = aresetn && live;
        full = wq.size() >= D || bq.size() >= D;
        g = locked;
        if (g < 0)
            for (int i = 0; i < N; i++) begin
                int p;
                p = (ptr + i) % N;
                if (bus.i_awvalid[p]) begin
                    g = p;
                    break;
                end
            end
        e_awv = en && !full && g >= 0 && bus.i_awvalid[g];
        e_awr = (e_awv && bus.o_awready) ? N'(1 << g) : '0;
        h = wq.size() > 0 ? wq[0] : -1;
        e_wv = en && h >= 0 && bus.i_wvalid[h];
        e_wr = (en && h >= 0 && bus.o_wready) ? N'(1 << h) : '0;
        b = bq.size() > 0 ? bq[0] : -1;
        e_bv = (en && b >= 0 && bus.o_bvalid) ? N'(1 << b) : '0;
        e_br = en && b >= 0 && bus.i_bready[b];
    endfunction

    function automatic void model_check();
        chk("o_awvalid", 32'(bus.o_awvalid), 32'(e_awv));
        chk("i_awready", 32'(bus.i_awready), 32'(e_awr));
        if (e_awv) chk("o_awch", 32'(bus.o_awch), 32'(bus.i_awch[g*AW +: AW]));
        chk("o_wvalid", 32'(bus.o_wvalid), 32'(e_wv));
        chk("i_wready", 32'(bus.i_wready), 32'(e_wr));
        if (e_wv) begin
            chk("o_wlast", 32'(bus.o_wlast), 32'(bus.i_wlast[h]));
            chk("o_wch", 32'(bus.o_wch), 32'(bus.i_wch[h*WW +: WW]));
        end
        chk("i_bvalid", 32'(bus.i_bvalid), 32'(e_bv));
        chk("o_bready", 32'(bus.o_bready), 32'(e_br));
        chk("i_bch", 32'(bus.i_bch), 32'(bus.o_bch));
    endfunction

    function automatic void model_update();
        if (!aresetn) begin
            wq.delete();
            bq.delete();
            ptr = 0;
            locked = -1;
            live = 1'b0;
        end else begin
            live = 1'b1;
            if (e_wv && bus.o_wready && bus.i_wlast[h]) void'(wq.pop_front());
            if (e_br && bus.o_bvalid) void'(bq.pop_front());
            if (e_awv && bus.o_awready) begin
                wq.push_back(g);
                bq.push_back(g);
                ptr = (g + 1) % N;
                locked = -1;
            end else if (e_awv) locked = g;
        end
    endfunction

    task automatic settle();
        @(negedge aclk);
        model_eval();
        if (use_model) model_check();
    endtask

    task automatic tick();
        @(posedge aclk);
        model_update();
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle_inputs();
        bus.i_awvalid = '0;
        bus.i_awch = 32'hA3A2A1A0;
        bus.i_wvalid = '0;
        bus.i_wlast = '0;
        bus.i_wch = '0;
        bus.i_bready = '0;
        bus.o_awready = 1'b0;
        bus.o_wready = 1'b0;
        bus.o_bvalid = 1'b0;
        bus.o_bch = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        aresetn = 1'b0;
        cyc();
        aresetn = 1'b1;
        cyc();
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_awvalid"}, 32'(bus.o_awvalid), 0);
        chk({tag, "_wvalid"}, 32'(bus.o_wvalid), 0);
        chk({tag, "_bready"}, 32'(bus.o_bready), 0);
        chk({tag, "_awready"}, 32'(bus.i_awready), 0);
        chk({tag, "_wready"}, 32'(bus.i_wready), 0);
        chk({tag, "_bvalid"}, 32'(bus.i_bvalid), 0);
    endtask

    typedef struct {
        logic [N-1:0]  awv;
        logic          awr;
        logic          exp_awv;
        logic [N-1:0]  exp_awr;
        logic [AW-1:0] exp_awch;
    } vec_t;
    vec_t tbl[10];

    int bt[N];
    bit hs[N];
    logic [7:0] got[$];
    logic [7:0] exp_w[8];

    task automatic drive_w();
        foreach (bt[p]) begin
            bus.i_wvalid[p] = (p == 1 || p == 3) && bt[p] < 4;
            bus.i_wlast[p] = bt[p] == 3;
            bus.i_wch[p*WW +: WW] = 8'(p * 16 + bt[p]);
        end
    endtask

    task automatic w_step();
        drive_w();
        settle();
        if (bus.o_wvalid && bus.o_wready) got.push_back(bus.o_wch);
        foreach (hs[p]) hs[p] = bus.i_wready[p] && bus.i_wvalid[p];
        tick();
        foreach (bt[p]) if (hs[p]) bt[p]++;
    endtask

    initial begin
        tbl[0] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 8'hA0};
        tbl[1] = '{4'b1111, 1'b1, 1'b1, 4'b0010, 8'hA1};
        tbl[2] = '{4'b1111, 1'b1, 1'b1, 4'b0100, 8'hA2};
        tbl[3] = '{4'b1111, 1'b1, 1'b1, 4'b1000, 8'hA3};
        tbl[4] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 8'hA0};
        tbl[5] = '{4'b0100, 1'b0, 1'b1, 4'b0000, 8'hA2};
        tbl[6] = '{4'b0110, 1'b0, 1'b1, 4'b0000, 8'hA2};
        tbl[7] = '{4'b0110, 1'b0, 1'b1, 4'b0000, 8'hA2};
        tbl[8] = '{4'b0110, 1'b1, 1'b1, 4'b0100, 8'hA2};
        tbl[9] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 8'hA1};
        exp_w = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h31, 8'h32, 8'h33};

        idle_inputs();
        tick();
        bus.i_awvalid = '1; bus.i_wvalid = '1; bus.i_wlast = '1; bus.i_bready = '1;
        bus.o_awready = 1'b1; bus.o_wready = 1'b1; bus.o_bvalid = 1'b1;
        settle();
        chk_quiet("rst");
        tick();
        aresetn = 1'b1;
        settle();
        chk_quiet("post_rst");
        tick();

        do_reset();
        bus.i_wvalid = '1; bus.i_wlast = '1; bus.o_wready = 1'b1; bus.o_bvalid = 1'b1; bus.i_bready = '1;
        for (int i = 0; i < 10; i++) begin
            bus.i_awvalid = tbl[i].awv;
            bus.o_awready = tbl[i].awr;
            settle();
            chk($sformatf("tbl%0d_awvalid", i), 32'(bus.o_awvalid), 32'(tbl[i].exp_awv));
            chk($sformatf("tbl%0d_awready", i), 32'(bus.i_awready), 32'(tbl[i].exp_awr));
            chk($sformatf("tbl%0d_awch", i), 32'(bus.o_awch), 32'(tbl[i].exp_awch));
            tick();
        end

        do_reset();
        foreach (bt[p]) bt[p] = 0;
        got.delete();
        bus.o_awready = 1'b1; bus.o_wready = 1'b1;
        bus.i_awvalid = 4'b0010;
        drive_w();
        settle();
        chk("w_before_aw_valid", 32'(bus.o_wvalid), 0);
        chk("w_before_aw_ready", 32'(bus.i_wready), 0);
        tick();
        bus.i_awvalid = 4'b1000;
        w_step();
        bus.i_awvalid = '0;
        for (int c = 0; c < 30 && got.size() < 8; c++) w_step();
        chk("w_beats", 32'(got.size()), 8);
        foreach (got[k]) if (k < 8) chk($sformatf("w_order%0d", k), 32'(got[k]), 32'(exp_w[k]));

        do_reset();
        bus.i_wvalid = 4'b0001; bus.i_wlast = 4'b0001; bus.o_wready = 1'b1;
        bus.i_awvalid = 4'b0001; bus.o_awready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("ostd_acc%0d", k), 32'(bus.i_awready), 1);
            tick();
        end
        settle();
        chk("ostd_stall_rdy", 32'(bus.i_awready), 0);
        chk("ostd_stall_valid", 32'(bus.o_awvalid), 0);
        tick();
        bus.o_bvalid = 1'b1; bus.i_bready = 4'b0001;
        settle();
        chk("ostd_b_hs", 32'(bus.o_bready), 1);
        chk("ostd_stall_pop", 32'(bus.i_awready), 0);
        tick();
        bus.o_bvalid = 1'b0;
        settle();
        chk("ostd_resume", 32'(bus.i_awready), 1);
        tick();

        do_reset();
        bus.o_awready = 1'b1;
        bus.i_awvalid = 4'b0001;
        cyc();
        bus.i_awvalid = 4'b0100;
        cyc();
        bus.i_awvalid = '0;
        bus.o_bvalid = 1'b1; bus.i_bready = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk($sformatf("b_hold%0d_bready", k), 32'(bus.o_bready), 0);
            chk($sformatf("b_hold%0d_bvalid", k), 32'(bus.i_bvalid), 1);
            tick();
        end
        bus.i_bready = 4'b0101;
        settle();
        chk("b_first_bready", 32'(bus.o_bready), 1);
        chk("b_first_bvalid", 32'(bus.i_bvalid), 1);
        tick();
        settle();
        chk("b_second_bready", 32'(bus.o_bready), 1);
        chk("b_second_bvalid", 32'(bus.i_bvalid), 4);
        tick();
        settle();
        chk("b_empty_bvalid", 32'(bus.i_bvalid), 0);
        chk("b_empty_bready", 32'(bus.o_bready), 0);
        tick();

        do_reset();
        bus.o_awready = 1'b1;
        bus.i_awvalid = 4'b0010;
        cyc();
        bus.i_awvalid = 4'b0100;
        cyc();
        bus.i_awvalid = '0;
        aresetn = 1'b0;
        cyc();
        aresetn = 1'b1;
        bus.i_awvalid = '1; bus.i_wvalid = '1; bus.o_wready = 1'b1; bus.o_bvalid = 1'b1; bus.i_bready = '1;
        settle();
        chk("mrst_first_awvalid", 32'(bus.o_awvalid), 0);
        tick();
        settle();
        chk("mrst_bready", 32'(bus.o_bready), 0);
        chk("mrst_wvalid", 32'(bus.o_wvalid), 0);
        chk("mrst_bvalid", 32'(bus.i_bvalid), 0);
        chk("mrst_grant0", 32'(bus.i_awready), 1);
        tick();

        use_model = 1'b1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            aresetn = $urandom_range(0, 99) != 0;
            bus.i_awvalid = N'($urandom) & N'($urandom);
            bus.i_awch = $urandom;
            bus.i_wvalid = N'($urandom);
            bus.i_wlast = N'($urandom) & N'($urandom);
            bus.i_wch = $urandom;
            bus.i_bready = N'($urandom);
            bus.o_awready = $urandom_range(0, 2) != 0;
            bus.o_wready = $urandom_range(0, 3) != 0;
            bus.o_bvalid = $urandom_range(0, 2) == 0;
            bus.o_bch = 8'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
